// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: holds the BCD MM:SS preset and running time, paces seconds
// from the 1 ms CE tick, interprets button pulses and drives display digits/enables/alarm.
module countdown_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned BLINK_TICKS   = 500,
  parameter int unsigned ALARM_SECS    = 10
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic        BTN_START,
  input  logic        BTN_STOP,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  output logic [15:0] DIGITS,
  output logic [7:0]  E_MASK,
  output logic        ALARM,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_SEC - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [7:0]  ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t      state_q, state_d;
  logic [15:0] preset_q, preset_d;
  logic [15:0] time_q, time_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  asec_q, asec_d;
  logic [15:0] digits_q, digits_d;
  logic [7:0]  emask_q, emask_d;
  logic        alarm_q, alarm_d;
  logic        sec_tick;

  // Add one second to a BCD MM:SS word; 99:59 wraps to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd9) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s10 != 4'd5) s10 = s10 + 4'd1;
      else begin
        s10 = 4'd0;
        if (m1 != 4'd9) m1 = m1 + 4'd1;
        else begin
          m1  = 4'd0;
          m10 = (m10 != 4'd9) ? m10 + 4'd1 : 4'd0;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Subtract one second from a BCD MM:SS word; 00:00 wraps to 99:59.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) s1 = s1 - 4'd1;
    else begin
      s1 = 4'd9;
      if (s10 != 4'd0) s10 = s10 - 4'd1;
      else begin
        s10 = 4'd5;
        if (m1 != 4'd0) m1 = m1 - 4'd1;
        else begin
          m1  = 4'd9;
          m10 = (m10 != 4'd0) ? m10 - 4'd1 : 4'd9;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign sec_tick = CE && (presc_q == PRESC_LAST);

  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    time_d      = time_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    asec_d      = asec_q;

    // Buttons take priority over CE in every state; a tick coinciding with an acting button is dropped.
    case (state_q)
      S_IDLE: begin
        if (!BTN_STOP) begin
          if (BTN_START) begin
            if (preset_q != 16'h0000) begin
              state_d = S_RUN;
              time_d  = preset_q;
              presc_d = 16'd0;
            end
          end else if (BTN_UP) begin
            preset_d = bcd_inc(preset_q);
            time_d   = preset_d;
          end else if (BTN_DOWN) begin
            preset_d = bcd_dec(preset_q);
            time_d   = preset_d;
          end
        end
      end
      S_RUN: begin
        if (BTN_STOP) begin
          state_d = S_IDLE;
          time_d  = preset_q;
        end else if (BTN_START) begin
          state_d     = S_PAUSE;
          phase_d     = 1'b1;
          blink_cnt_d = 16'd0;
        end else if (sec_tick) begin
          presc_d = 16'd0;
          time_d  = bcd_dec(time_q);
          if (time_d == 16'h0000) begin
            state_d     = S_DONE;
            asec_d      = 8'd0;
            phase_d     = 1'b1;
            blink_cnt_d = 16'd0;
          end
        end else if (CE) begin
          presc_d = presc_q + 16'd1;
        end
      end
      S_PAUSE: begin
        if (BTN_STOP) begin
          state_d = S_IDLE;
          time_d  = preset_q;
        end else if (BTN_START) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (BTN_STOP || BTN_START) begin
          state_d = S_IDLE;
          time_d  = preset_q;
        end else if (sec_tick) begin
          presc_d = 16'd0;
          if (asec_q == ALARM_LAST) begin
            state_d = S_IDLE;
            time_d  = preset_q;
          end else begin
            asec_d = asec_q + 8'd1;
          end
        end else if (CE) begin
          presc_d = presc_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = preset_q;
      end
    endcase

    if (CE && (state_d == state_q) && (state_q == S_PAUSE || state_q == S_DONE)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    digits_d = (state_d == S_IDLE) ? preset_d : time_d;
    emask_d  = 8'h0F;
    if ((state_d == S_PAUSE || state_d == S_DONE) && !phase_d) emask_d = 8'h00;
    alarm_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= S_IDLE;
      preset_q    <= 16'h0000;
      time_q      <= 16'h0000;
      presc_q     <= 16'd0;
      blink_cnt_q <= 16'd0;
      phase_q     <= 1'b1;
      asec_q      <= 8'd0;
      digits_q    <= 16'h0000;
      emask_q     <= 8'h0F;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      asec_q      <= asec_d;
      digits_q    <= digits_d;
      emask_q     <= emask_d;
      alarm_q     <= alarm_d;
    end
  end

  assign DIGITS = digits_q;
  assign E_MASK = emask_q;
  assign ALARM  = alarm_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with short timing parameters (4 ticks/s, blink 5, alarm 2 s).
module tb_countdown_ctrl;

  logic        clk;
  logic        clr;
  logic        ce;
  logic        btn_start;
  logic        btn_stop;
  logic        btn_up;
  logic        btn_down;
  logic [15:0] digits;
  logic [7:0]  e_mask;
  logic        alarm;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(
    .TICKS_PER_SEC(4),
    .BLINK_TICKS  (5),
    .ALARM_SECS   (2)
  ) dut (
    .CLK      (clk),
    .CLR      (clr),
    .CE       (ce),
    .BTN_START(btn_start),
    .BTN_STOP (btn_stop),
    .BTN_UP   (btn_up),
    .BTN_DOWN (btn_down),
    .DIGITS   (digits),
    .E_MASK   (e_mask),
    .ALARM    (alarm),
    .STATE    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs, applied and released at negedges.
  task automatic cyc(input logic c, input logic st, input logic sp, input logic up, input logic dn);
    ce = c; btn_start = st; btn_stop = sp; btn_up = up; btn_down = dn;
    @(negedge clk);
    ce = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic ces(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic downs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d, input logic [7:0] m,
                           input logic a, input logic [2:0] s);
    check({tag, "_digits"}, digits, d);
    check({tag, "_emask"}, {8'h00, e_mask}, {8'h00, m});
    check({tag, "_alarm"}, {15'h0, alarm}, {15'h0, a});
    check({tag, "_state"}, {13'h0, state}, {13'h0, s});
  endtask

  initial begin
    clr = 1'b0; ce = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check_all("in_reset", 16'h0000, 8'h0F, 1'b0, 3'd0);
    clr = 1'b1;
    @(negedge clk);
    check_all("after_reset", 16'h0000, 8'h0F, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("start_zero_preset", 16'h0000, 8'h0F, 1'b0, 3'd0);

    // Basic countdown to DONE and alarm timeout.
    ups(3);
    check("preset_3", digits, 16'h0003);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("run_start", 16'h0003, 8'h0F, 1'b0, 3'd1);
    ces(4);
    check("run_4ce", digits, 16'h0002);
    ces(7);
    check_all("run_11ce", 16'h0001, 8'h0F, 1'b0, 3'd1);
    ces(1);
    check_all("done_entry", 16'h0000, 8'h0F, 1'b1, 3'd3);
    ces(5);
    check_all("done_blink", 16'h0000, 8'h00, 1'b1, 3'd3);
    ces(2);
    check_all("done_7ce", 16'h0000, 8'h00, 1'b1, 3'd3);
    ces(1);
    check_all("alarm_timeout", 16'h0003, 8'h0F, 1'b0, 3'd0);

    // Minute borrow and wrap-around boundaries.
    downs(3);
    check("preset_back_0", digits, 16'h0000);
    ups(59);
    check("preset_59", digits, 16'h0059);
    ups(1);
    check("preset_100", digits, 16'h0100);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ups(1);
    check_all("run_up_ignored", 16'h0100, 8'h0F, 1'b0, 3'd1);
    ces(4);
    check("run_minute_borrow", digits, 16'h0059);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("stop_reload", 16'h0100, 8'h0F, 1'b0, 3'd0);
    downs(60);
    check("preset_down_0", digits, 16'h0000);
    downs(1);
    check("wrap_down", digits, 16'h9959);
    ups(1);
    check("wrap_up", digits, 16'h0000);

    // Pause with blink, then resume from held prescaler.
    ups(5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ces(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("pause_entry", 16'h0005, 8'h0F, 1'b0, 3'd2);
    ces(5);
    check("pause_blink_5", {8'h00, e_mask}, 16'h0000);
    ces(5);
    check("pause_blink_10", {8'h00, e_mask}, 16'h000F);
    ces(5);
    check("pause_blink_15", {8'h00, e_mask}, 16'h0000);
    ces(5);
    check_all("pause_blink_20", 16'h0005, 8'h0F, 1'b0, 3'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("resume", 16'h0005, 8'h0F, 1'b0, 3'd1);
    ces(2);
    check("resume_2ce", digits, 16'h0004);

    // Button coinciding with terminal tick, and STOP over START.
    ces(3);
    check("pre_terminal", digits, 16'h0004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("start_on_terminal", 16'h0004, 8'h0F, 1'b0, 3'd2);
    ups(1);
    check("pause_up_ignored", digits, 16'h0004);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ces(1);
    check("held_terminal", digits, 16'h0003);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("stop_over_start", 16'h0005, 8'h0F, 1'b0, 3'd0);

    // START in DONE returns to IDLE at once.
    downs(4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ces(4);
    check_all("done_short", 16'h0000, 8'h0F, 1'b1, 3'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("done_start_ack", 16'h0001, 8'h0F, 1'b0, 3'd0);

    // Asynchronous reset mid-run.
    ups(36);
    check("preset_37", digits, 16'h0037);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ces(1);
    #2 clr = 1'b0;
    #1;
    check_all("async_clr", 16'h0000, 8'h0F, 1'b0, 3'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("preset_cleared", 16'h0000, 8'h0F, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
